// File: rtl/nfifo_rr_reader_if.sv
// Signal bundle between the round-robin reader, the NFIFO read port and the downstream sink.
// master = reader side, slave = NFIFO + sink side.
interface nfifo_rr_reader_if #(
  parameter int DATA_WIDTH = 64,
  parameter int FLOWS      = 4,
  parameter int AW         = (FLOWS > 1) ? $clog2(FLOWS) : 1
);
  logic [FLOWS-1:0]      empty;
  logic [AW-1:0]         rd_blk_addr;
  logic                  read;
  logic                  pipe_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_vld;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [AW-1:0]         tx_flow;
  logic                  tx_vld;
  logic                  tx_rdy;
  logic [31:0]           stat_words;

  modport master (
    input  empty, data_out, data_vld, tx_rdy,
    output rd_blk_addr, read, pipe_en, tx_data, tx_flow, tx_vld, stat_words
  );
  modport slave (
    output empty, data_out, data_vld, tx_rdy,
    input  rd_blk_addr, read, pipe_en, tx_data, tx_flow, tx_vld, stat_words
  );
endinterface

// File: rtl/nfifo_rr_reader.sv
// Round-robin burst reader draining NFIFO flows into a 4-entry credit-limited buffer.
// Optional macro NFIFO_RR_READER_STATS_EN enables the STAT_WORDS transfer counter.
module nfifo_rr_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int FLOWS      = 4,
  parameter bit OUTPUT_REG = 1'b0,
  parameter int BURST      = 8
) (
  input logic               clk,
  input logic               reset,
  nfifo_rr_reader_if.master bus
);
  localparam int AW  = (FLOWS > 1) ? $clog2(FLOWS) : 1;
  localparam int LAT = OUTPUT_REG ? 2 : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_BURST} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [AW-1:0]         flow;
  } ent_t;

  state_t        state;
  logic [AW-1:0] sel, last, pick;
  logic [7:0]    bcnt;
  logic          rd_en;
  ent_t          fifo_q [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    occ, infl;
  logic [AW-1:0] tag_pipe [LAT];
  logic [2*FLOWS-1:0] rot;
  logic          rd, push, pop, tx_vld, credit_ok;

  // Buffer slots are reserved at read time, so the buffer can never overflow.
  assign credit_ok = (occ + infl) < 3'd4;
  assign rd        = reset & rd_en & ~bus.empty[sel] & credit_ok;
  assign push      = bus.data_vld & (infl != 3'd0);
  assign tx_vld    = (occ != 3'd0);
  assign pop       = tx_vld & bus.tx_rdy;

  // Rotate the non-empty mask so bit 0 is the flow right after the last one served.
  always_comb begin
    rot  = {~bus.empty, ~bus.empty} >> (int'(last) + 1);
    pick = last;
    for (int j = FLOWS - 1; j >= 0; j--)
      if (rot[j]) pick = AW'((int'(last) + 1 + j) % FLOWS);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      sel   <= '0;
      last  <= AW'(FLOWS - 1);
      bcnt  <= '0;
      rd_en <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (!(&bus.empty)) state <= S_ARB;
        S_ARB: begin
          if (&bus.empty) state <= S_IDLE;
          else begin
            sel   <= pick;
            last  <= pick;
            bcnt  <= '0;
            rd_en <= 1'b1;
            state <= S_BURST;
          end
        end
        S_BURST: begin
          if (rd) bcnt <= bcnt + 8'd1;
          if (&bus.empty) begin
            state <= S_IDLE;
            rd_en <= 1'b0;
          end else if (bus.empty[sel] || (rd && (bcnt + 8'd1) == 8'(BURST))) begin
            state <= S_ARB;
            rd_en <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tags shift every cycle; NFIFO latency is fixed, so the tag at depth LAT-1 matches DATA_VLD.
  always_ff @(posedge clk) begin
    if (!reset) begin
      occ    <= '0;
      infl   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      for (int i = 0; i < LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= sel;
      for (int i = 1; i < LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      if (push) begin
        fifo_q[wr_ptr].data <= bus.data_out;
        fifo_q[wr_ptr].flow <= tag_pipe[LAT-1];
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      occ  <= occ + 3'(push) - 3'(pop);
      infl <= infl + 3'(rd) - 3'(push);
    end
  end

  assign bus.rd_blk_addr = sel;
  assign bus.read        = rd;
  assign bus.pipe_en     = reset;
  assign bus.tx_vld      = tx_vld;
  assign bus.tx_data     = fifo_q[rd_ptr].data;
  assign bus.tx_flow     = fifo_q[rd_ptr].flow;

`ifdef NFIFO_RR_READER_STATS_EN
  logic [31:0] stat_cnt;
  always_ff @(posedge clk) begin
    if (!reset)   stat_cnt <= '0;
    else if (pop) stat_cnt <= stat_cnt + 32'd1;
  end
  assign bus.stat_words = stat_cnt;
`else
  assign bus.stat_words = 32'd0;
`endif
endmodule

// File: tb/tb_nfifo_rr_reader.sv
// Bench for nfifo_rr_reader: NFIFO/sink model with queues, per-cycle output compare, directed scenarios.
module tb_nfifo_rr_reader;
  localparam int DW = 64, FL = 4, AW = 2, BST = 8, LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  nfifo_rr_reader_if #(.DATA_WIDTH(DW), .FLOWS(FL)) bus ();
  nfifo_rr_reader #(.DATA_WIDTH(DW), .FLOWS(FL), .OUTPUT_REG(1'b1), .BURST(BST))
    dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { logic [DW-1:0] d; logic [AW-1:0] f; } ent_t;

  int nvec = 0, nmis = 0;
  int avail [FL];
  int nseq  [FL];
  logic          rv [LAT];
  logic          rs [LAT];
  logic [DW-1:0] rdat [LAT];
  logic [AW-1:0] rfl [LAT];
  ent_t bq [$];
  int rlog [$];
  int txlog [$];
  logic [31:0] xcnt = 0;
  logic s_rst, s_rd, s_xfer, s_arr;
  logic [AW-1:0] s_addr, s_flow;
  int ef [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
  int en [12] = '{8, 8, 8, 8, 8, 8, 8, 8, 4, 4, 4, 4};

  function automatic logic [DW-1:0] word(int f, int n);
    return {16'hD0D0, 16'(f), 32'(n)};
  endfunction

  function automatic int live();
    int n = 0;
    for (int i = 0; i < LAT; i++) if (rv[i] && !rs[i]) n++;
    return n;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive_nfifo();
    for (int f = 0; f < FL; f++) bus.empty[f] = (avail[f] == 0);
    bus.data_vld = rv[LAT-1];
    bus.data_out = rv[LAT-1] ? rdat[LAT-1] : '0;
  endtask

  // One clock: compare at negedge, then advance the NFIFO/buffer model just after posedge.
  task automatic step();
    @(negedge clk);
    s_rst  = !reset;
    s_rd   = reset && bus.read;
    s_addr = bus.rd_blk_addr;
    s_flow = bus.tx_flow;
    s_xfer = reset && bus.tx_vld && bus.tx_rdy;
    s_arr  = reset && rv[LAT-1] && !rs[LAT-1];
    chk("pipe_en", bus.pipe_en, reset);
    if (!reset) chk("rd_in_rst", bus.read, 0);
    else begin
      chk("tx_vld", bus.tx_vld, bq.size() != 0);
      if (bq.size() != 0) begin
        chk("tx_data", bus.tx_data, bq[0].d);
        chk("tx_flow", bus.tx_flow, bq[0].f);
      end
      if (s_rd) begin
        chk("rd_nonempty", avail[s_addr] > 0, 1);
        chk("rd_credit", (bq.size() + live()) < 4, 1);
        rlog.push_back(s_addr);
      end
`ifdef NFIFO_RR_READER_STATS_EN
      chk("stat_words", bus.stat_words, xcnt);
`else
      chk("stat_words", bus.stat_words, 0);
`endif
    end
    @(posedge clk);
    #1;
    if (s_xfer) begin
      void'(bq.pop_front());
      txlog.push_back(s_flow);
      xcnt = xcnt + 32'd1;
    end
    if (s_arr) bq.push_back('{d: rdat[LAT-1], f: rfl[LAT-1]});
    for (int i = LAT - 1; i > 0; i--) begin
      rv[i] = rv[i-1]; rs[i] = rs[i-1]; rdat[i] = rdat[i-1]; rfl[i] = rfl[i-1];
    end
    rv[0] = s_rd; rs[0] = 1'b0; rdat[0] = '0; rfl[0] = s_addr;
    if (s_rd && avail[s_addr] > 0) begin
      rdat[0] = word(s_addr, nseq[s_addr]);
      nseq[s_addr]++;
      avail[s_addr]--;
    end
    // Reads in flight at reset still come back from the NFIFO but must be dropped.
    if (s_rst) begin
      bq.delete();
      xcnt = 0;
      for (int i = 0; i < LAT; i++) rs[i] = 1'b1;
    end
    drive_nfifo();
  endtask

  function automatic bit quiet();
    for (int f = 0; f < FL; f++) if (avail[f] != 0) return 0;
    return (bq.size() == 0) && (live() == 0);
  endfunction

  task automatic drain(string nm, int maxc);
    int c = 0;
    while (c < maxc && !quiet()) begin step(); c++; end
    chk({nm, "_drain"}, c < maxc, 1);
    repeat (4) step();
  endtask

  initial begin
    int rf_q [$];
    int rn_q [$];
    int c;
    for (int f = 0; f < FL; f++) begin avail[f] = 0; nseq[f] = 0; end
    for (int i = 0; i < LAT; i++) begin rv[i] = 0; rs[i] = 0; rdat[i] = '0; rfl[i] = '0; end
    bus.tx_rdy = 1'b0;
    drive_nfifo();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read", bus.read, 0);
    chk("rst_pipe_en", bus.pipe_en, 0);
    chk("rst_tx_vld", bus.tx_vld, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_tx_flow", bus.tx_flow, 0);
    chk("rst_addr", bus.rd_blk_addr, 0);
    chk("rst_stat", bus.stat_words, 0);
    reset = 1'b1;
    #1;
    chk("pipe_en_up", bus.pipe_en, 1);
    repeat (3) step();

    // All flows loaded with 20 words: round-robin bursts of at most 8
    bus.tx_rdy = 1'b1;
    for (int f = 0; f < FL; f++) avail[f] = 20;
    drive_nfifo();
    rlog.delete();
    drain("rr", 2000);
    foreach (rlog[i]) begin
      if (i == 0 || rlog[i] != rlog[i-1]) begin rf_q.push_back(rlog[i]); rn_q.push_back(1); end
      else rn_q[rn_q.size()-1]++;
    end
    chk("rr_runs", rf_q.size(), 12);
    for (int i = 0; i < 12 && i < rf_q.size(); i++) begin
      chk("rr_flow", rf_q[i], ef[i]);
      chk("rr_len", rn_q[i], en[i]);
    end

    // Flow 2 with 3 words
    rlog.delete(); txlog.delete();
    avail[2] = 3;
    drive_nfifo();
    drain("f2", 200);
    chk("f2_reads", rlog.size(), 3);
    foreach (rlog[i]) chk("f2_addr", rlog[i], 2);
    chk("f2_xfers", txlog.size(), 3);
    foreach (txlog[i]) chk("f2_txflow", txlog[i], 2);
    chk("f2_idle_read", bus.read, 0);

    // Downstream stalled: credit caps reads at 4, head word held
    rlog.delete(); txlog.delete();
    bus.tx_rdy = 1'b0;
    avail[0] = 10;
    drive_nfifo();
    repeat (30) step();
    chk("stall_reads", rlog.size(), 4);
    chk("stall_vld", bus.tx_vld, 1);
    chk("stall_head", bus.tx_data, 64'hD0D0_0000_0000_0014);
    bus.tx_rdy = 1'b1;
    drain("stall", 400);
    chk("stall_xfers", txlog.size(), 10);

    // Reset one cycle after a read: returning data must be dropped
    rlog.delete(); txlog.delete();
    avail[1] = 5;
    drive_nfifo();
    c = 0;
    do begin step(); c++; end while (!s_rd && c < 20);
    chk("mid_rst_read_seen", s_rd, 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_rst_vld", bus.tx_vld, 0);
      chk("mid_rst_stat", bus.stat_words, 0);
    end
    drain("mid_rst", 400);
    chk("mid_rst_xfers", txlog.size(), 4);

`ifdef NFIFO_RR_READER_STATS_EN
    // Counter wraps from all-ones to zero
    force dut.stat_cnt = 32'hFFFF_FFFF;
    xcnt = 32'hFFFF_FFFF;
    step();
    release dut.stat_cnt;
    avail[3] = 1;
    drive_nfifo();
    drain("wrap", 200);
    chk("stat_wrap", bus.stat_words, 32'h0000_0000);
`else
    chk("stat_off", bus.stat_words, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
